// File: rtl/gpio_atr_ctrl.sv
// rtl/gpio_atr_ctrl.sv - GPIO block with automatic TX/RX (ATR) pin value switching.
// Optional ATR delay register, counter and WAIT state are built when GPIO_ATR_DELAY_EN is defined.
module gpio_atr_ctrl #(
   parameter logic [6:0] BASE = 7'd0
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_serial_strobe,
   input  logic [6:0]  i_serial_addr,
   input  logic [31:0] i_serial_data,
   input  logic        i_tx_enable,
   input  logic        i_rx_enable,
   input  logic [15:0] i_io_in,
   output logic [15:0] o_oe,
   output logic [15:0] o_reg_val,
   output logic [15:0] o_readback,
   output logic [1:0]  o_atr_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RX   = 2'd1;
   localparam logic [1:0] S_TX   = 2'd2;
   localparam logic [1:0] S_WAIT = 2'd3;

   logic [15:0] r_oe, r_out, r_mask, r_txval, r_rxval;
   logic [15:0] r_reg_val, r_rb_meta, r_rb;
   logic [1:0]  r_state, w_next;
   logic [1:0]  w_idle_rx;
   logic [15:0] w_sel;
   logic        w_tx_exit, w_wait_done;

   function automatic logic [15:0] f_merge(input logic [15:0] cur, input logic [31:0] d);
      return (cur & ~d[31:16]) | (d[15:0] & d[31:16]);
   endfunction

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_oe    <= '0;
         r_out   <= '0;
         r_mask  <= '0;
         r_txval <= '0;
         r_rxval <= '0;
      end else if (i_serial_strobe) begin
         case (i_serial_addr)
            BASE + 7'd0: r_oe    <= f_merge(r_oe, i_serial_data);
            BASE + 7'd1: r_out   <= f_merge(r_out, i_serial_data);
            BASE + 7'd2: r_mask  <= f_merge(r_mask, i_serial_data);
            BASE + 7'd3: r_txval <= f_merge(r_txval, i_serial_data);
            BASE + 7'd4: r_rxval <= f_merge(r_rxval, i_serial_data);
            default: ;
         endcase
      end
   end

`ifdef GPIO_ATR_DELAY_EN
   logic [11:0] r_delay, r_count;

   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_delay <= '0;
      else if (i_serial_strobe && i_serial_addr == BASE + 7'd5)
         r_delay <= i_serial_data[11:0];
   end

   // The count is captured on WAIT entry, so later delay writes leave it alone.
   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_count <= '0;
      else if (r_state == S_TX && !i_tx_enable && r_delay != 12'd0)
         r_count <= r_delay;
      else if (r_state == S_WAIT && r_count != 12'd0)
         r_count <= r_count - 12'd1;
   end

   assign w_tx_exit   = (r_delay == 12'd0);
   assign w_wait_done = (r_count == 12'd1);
`else
   assign w_tx_exit   = 1'b1;
   assign w_wait_done = 1'b1;
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   assign w_idle_rx = i_rx_enable ? S_RX : S_IDLE;

   always_comb begin
      w_next = w_idle_rx;
      if (i_tx_enable) begin
         w_next = S_TX;
      end else begin
         case (r_state)
            S_TX:    w_next = w_tx_exit ? w_idle_rx : S_WAIT;
            S_WAIT:  w_next = w_wait_done ? w_idle_rx : S_WAIT;
            default: w_next = w_idle_rx;
         endcase
      end
   end

   always_comb begin
      w_sel = r_out;
      case (r_state)
         S_TX, S_WAIT: w_sel = r_txval;
         S_RX:         w_sel = r_rxval;
         default:      w_sel = r_out;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_reg_val <= '0;
         r_rb_meta <= '0;
         r_rb      <= '0;
      end else begin
         r_reg_val <= (r_out & ~r_mask) | (w_sel & r_mask);
         r_rb_meta <= i_io_in;
         r_rb      <= r_rb_meta;
      end
   end

   assign o_oe        = r_oe;
   assign o_reg_val   = r_reg_val;
   assign o_readback  = r_rb;
   assign o_atr_state = r_state;

endmodule

// File: doc/gpio_atr_ctrl.md
GPIO_ATR_CTRL -- requirements
Module: gpio_atr_ctrl

Interface
REQ-001 Parameter BASE, default 7'd0: first serial register address; the block decodes BASE..BASE+5.
REQ-002 clock  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 serial_strobe  in  1  one-cycle write strobe.
REQ-005 serial_addr  in  7  register address.
REQ-006 serial_data  in  32  write data: [31:16] bit mask, [15:0] value.
REQ-007 tx_enable  in  1  transmit path active.
REQ-008 rx_enable  in  1  receive path active.
REQ-009 io_in  in  16  pin levels read back from the tristate pins (asynchronous).
REQ-010 oe  out  16  per-pin output enable for the bidirectional pin driver.
REQ-011 reg_val  out  16  per-pin drive value for the bidirectional pin driver.
REQ-012 readback  out  16  synchronized pin levels.
REQ-013 atr_state  out  2  current ATR state: 0 IDLE, 1 RX, 2 TX, 3 WAIT.

Function
REQ-014 Registers: BASE+0 OE, BASE+1 OUT, BASE+2 ATR_MASK, BASE+3 ATR_TXVAL, BASE+4 ATR_RXVAL, BASE+5 ATR_DELAY (12 bits, serial_data[11:0]).
REQ-015 Writes to BASE+0..BASE+4 with serial_strobe high: reg <= (reg & ~mask) | (value & mask); the result is visible in the register the next cycle.
REQ-016 ATR_DELAY writes take serial_data[11:0] unmasked; writes to other addresses are ignored.
REQ-017 oe is driven directly from OE (registered; 1 cycle after the write strobe).
REQ-018 ATR states and transitions (evaluated every cycle; tx_enable has priority):
- any state with tx_enable=1 -> TX;
- TX with tx_enable=0: if ATR_DELAY=0 -> RX when rx_enable=1, else IDLE; otherwise -> WAIT, loading counter=ATR_DELAY;
- WAIT: counter decrements each cycle; when counter=1 -> RX when rx_enable=1, else IDLE;
- IDLE/RX: -> RX when rx_enable=1, else IDLE.
REQ-019 WAIT duration equals ATR_DELAY cycles. An ATR_DELAY write during WAIT does not alter the running count.
REQ-020 ATR value selection: sel = ATR_TXVAL in TX or WAIT, ATR_RXVAL in RX, OUT in IDLE.
REQ-021 reg_val is registered: reg_val <= (OUT & ~ATR_MASK) | (sel & ATR_MASK), using the current-cycle state and register values. reg_val lags a state change by 1 cycle and a register write by 2 cycles.
REQ-022 If a write and a state change occur in the same cycle, both take effect; no write is dropped.
REQ-023 readback = io_in passed through two flip-flop stages; latency is 2 cycles.

Reset
REQ-024 While reset=1: OE, OUT, ATR_MASK, ATR_TXVAL, ATR_RXVAL, ATR_DELAY, counter, oe, reg_val and readback are all 0, and state is IDLE (atr_state=0).
REQ-025 Reset asserted during WAIT or TX aborts the operation. The first post-reset cycle evaluates from IDLE.
REQ-026 serial_strobe is ignored while reset=1.

Configuration
REQ-027 Macro GPIO_ATR_DELAY_EN.
- Defined: ATR_DELAY register, 12-bit counter and WAIT state are present, per REQ-018/019.
- Undefined: no ATR_DELAY register, counter or WAIT state. TX with tx_enable=0 goes directly to RX/IDLE. Writes to BASE+5 are ignored. atr_state never equals 3.

Verification
REQ-028 Write BASE+0 data 0x00FF_00A5, then 0x0F00_FFFF -> oe=0x00A5, then 0x0FA5.
REQ-029 OUT=0x1234, ATR_MASK=0x00F0, ATR_RXVAL=0x00A0, then rx_enable=1 -> reg_val=0x1234 in IDLE, 0x12A4 one cycle after atr_state=1.
REQ-030 ATR_TXVAL=0x0050, ATR_DELAY=3, tx_enable high 5 cycles then low with rx_enable=1 -> atr_state 2, then 3 for exactly 3 cycles, then 1; reg_val=0x1254 through WAIT, then 0x12A4.
REQ-031 tx_enable reasserted on the 2nd WAIT cycle -> atr_state returns to 2 with no RX interval.
REQ-032 io_in steps 0x0000->0xBEEF -> readback=0xBEEF exactly 2 cycles later; reset pulse mid-WAIT -> all outputs 0 and atr_state=0 on the next edge.
REQ-033 With GPIO_ATR_DELAY_EN undefined, repeat REQ-030 -> atr_state goes 2 -> 1 directly and the BASE+5 write has no effect.
